// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode.
// Two-wide circular buffer: up to two instructions enqueued and two presented per
// cycle, in program order. A flush (redirect) empties the queue and has priority
// over enqueue and dequeue in the same cycle.
module fetch_queue #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [1:0]                 in_valid,
    input  logic [ADDR_WIDTH-1:0]      in_addr_0,
    input  logic [ADDR_WIDTH-1:0]      in_addr_1,
    input  logic [DATA_WIDTH-1:0]      in_instr_0,
    input  logic [DATA_WIDTH-1:0]      in_instr_1,
    output logic                       in_ready,
    output logic [1:0]                 out_valid,
    output logic [ADDR_WIDTH-1:0]      out_addr_0,
    output logic [ADDR_WIDTH-1:0]      out_addr_1,
    output logic [DATA_WIDTH-1:0]      out_instr_0,
    output logic [DATA_WIDTH-1:0]      out_instr_1,
    input  logic [1:0]                 out_accept,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam logic [PTR_W:0] DEPTH_W = (PTR_W + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] r_addr  [DEPTH];
    logic [DATA_WIDTH-1:0] r_instr [DEPTH];
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;

    logic [PTR_W-1:0]      w_count;
    logic [IDX_W-1:0]      w_rd_idx_0;
    logic [IDX_W-1:0]      w_rd_idx_1;
    logic [IDX_W-1:0]      w_wr_idx_0;
    logic [IDX_W-1:0]      w_wr_idx_1;
    logic [1:0]            w_take;
    logic [PTR_W-1:0]      w_deq_n;
    logic [PTR_W-1:0]      w_enq_n;
    logic                  w_enq_ok;
    logic                  w_wr0;
    logic                  w_wr1;
    logic [ADDR_WIDTH-1:0] w_wr0_addr;
    logic [DATA_WIDTH-1:0] w_wr0_instr;

    assign w_count    = r_tail - r_head;
    assign count      = w_count;
    // Readiness looks only at registered occupancy; a same-cycle dequeue is not credited.
    assign in_ready   = ({1'b0, w_count} + (PTR_W + 1)'(2)) <= DEPTH_W;
    assign out_valid  = {w_count > PTR_W'(1), w_count != '0};

    assign w_rd_idx_0 = r_head[IDX_W-1:0];
    assign w_rd_idx_1 = r_head[IDX_W-1:0] + IDX_W'(1);
    assign w_wr_idx_0 = r_tail[IDX_W-1:0];
    assign w_wr_idx_1 = r_tail[IDX_W-1:0] + IDX_W'(1);

    // Combinational read of the two oldest entries; invalid slots read as zero.
    always_comb begin
        out_addr_0  = '0;
        out_instr_0 = '0;
        out_addr_1  = '0;
        out_instr_1 = '0;
        if (out_valid[0]) begin
            out_addr_0  = r_addr[w_rd_idx_0];
            out_instr_0 = r_instr[w_rd_idx_0];
        end
        if (out_valid[1]) begin
            out_addr_1  = r_addr[w_rd_idx_1];
            out_instr_1 = r_instr[w_rd_idx_1];
        end
    end

    // Dequeue count: accept bits masked by valid; a lone slot1 accept (10) is dropped.
    always_comb begin
        w_take  = out_accept & out_valid;
        w_deq_n = '0;
        if (w_take[0]) begin
            w_deq_n = w_take[1] ? PTR_W'(2) : PTR_W'(1);
        end
    end

    // Enqueue decode: a lone slot1 is compacted into the tail slot.
    always_comb begin
        w_enq_ok    = in_ready && !flush;
        w_wr0       = w_enq_ok && (in_valid != 2'b00);
        w_wr1       = w_enq_ok && (in_valid == 2'b11);
        w_wr0_addr  = in_valid[0] ? in_addr_0 : in_addr_1;
        w_wr0_instr = in_valid[0] ? in_instr_0 : in_instr_1;
        w_enq_n     = '0;
        if (w_wr1) begin
            w_enq_n = PTR_W'(2);
        end else if (w_wr0) begin
            w_enq_n = PTR_W'(1);
        end
    end

    // Storage array write; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_wr0) begin
            r_addr[w_wr_idx_0]  <= w_wr0_addr;
            r_instr[w_wr_idx_0] <= w_wr0_instr;
        end
        if (w_wr1) begin
            r_addr[w_wr_idx_1]  <= in_addr_1;
            r_instr[w_wr_idx_1] <= in_instr_1;
        end
    end

    // Head/tail pointer update; flush overrides both enqueue and dequeue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (flush) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            r_head <= r_head + w_deq_n;
            r_tail <= r_tail + w_enq_n;
        end
    end

    // Occupancy must stay within 0..DEPTH.
    assert property (@(posedge clk) disable iff (!rst) w_count <= PTR_W'(DEPTH));

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Instruction fetch queue sitting directly downstream of InstructionFetch and upstream of decode/rename. It accepts up to two instructions per cycle from the fetch stage and stores them in a circular buffer. It presents up to two instructions per cycle, in program order, to decode. It decouples fetch from decode stalls and drops all buffered instructions on a redirect (jump or flush).

Parameters:
ADDR_WIDTH, 32, width of instruction address
DATA_WIDTH, 32, width of instruction word
DEPTH, 8, number of entries; power of two, >= 4

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  asynchronous active-low reset
flush  input  1  redirect (isJump/mispredict); discard all entries
in_valid  input  2  per-slot valid from fetch; bit0 = slot0 (older), bit1 = slot1
in_addr_0  input  ADDR_WIDTH  slot0 instruction address
in_addr_1  input  ADDR_WIDTH  slot1 instruction address
in_instr_0  input  DATA_WIDTH  slot0 instruction word
in_instr_1  input  DATA_WIDTH  slot1 instruction word
in_ready  output  1  queue can take a full pair this cycle
out_valid  output  2  per-slot valid to decode; only 00, 01 or 11
out_addr_0  output  ADDR_WIDTH  oldest entry address
out_addr_1  output  ADDR_WIDTH  second-oldest entry address
out_instr_0  output  DATA_WIDTH  oldest entry instruction
out_instr_1  output  DATA_WIDTH  second-oldest entry instruction
out_accept  input  2  decode consumes slots; legal 00, 01, 11, subset of out_valid
count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Storage: DEPTH-entry array of {addr, instr}.
- head/tail pointers are $clog2(DEPTH)+1 bits; the index is the low bits; the extra bit distinguishes full from empty.
- count = tail - head (modular).
- Reset (rst low, async): head = tail = 0, count = 0, out_valid = 00, in_ready = 1, out_addr/out_instr = 0. Array contents need no reset.
- in_ready = (DEPTH - count) >= 2, combinational from registered count only.
  - in_ready does not credit a same-cycle dequeue.
- Enqueue at posedge when in_ready = 1 and flush = 0:
  - 11: slot0 written at tail, slot1 at tail+1, tail += 2.
  - 01: slot0 at tail, tail += 1.
  - 10: slot1 at tail, tail += 1 (compacted, no bubble).
  - 00: no change.
- If in_ready = 0, in_valid is ignored and nothing is written. Fetch must hold or replay.
- Outputs are combinational reads of array[head] and array[head+1] (zero-cycle read latency).
  - out_valid[0] = (count >= 1), out_valid[1] = (count >= 2).
  - Address/instr of an invalid slot is driven 0.
- Dequeue at posedge when flush = 0: head += popcount(out_accept & out_valid).
  - Illegal out_accept (10, or a bit without its out_valid bit) is masked; no state corruption.
- Simultaneous enqueue and dequeue in the same cycle are both applied: count_next = count + enq - deq.
- Enqueue after dequeue: a newly enqueued instruction is visible on out_* no earlier than the next cycle (no bypass).
- Flush has priority over enqueue and dequeue in the same cycle.
  - Next state: head = tail = 0, count = 0.
  - Next cycle: out_valid = 00, in_ready = 1.
  - Instructions presented with flush are discarded.
- Wrap-around: index arithmetic is modulo DEPTH. Program order is preserved across the wrap.
- Reset asserted mid-operation: immediate empty state regardless of clock.
  - First enqueue is accepted on the first posedge after rst deasserts.
- Invariant: count never exceeds DEPTH and never underflows. A simulation assertion flags any violation.

Test Plan:
1. Reset: hold rst=0, toggle clk -> out_valid=00, count=0, in_ready=1, out_addr_0=0. Release rst -> state unchanged until first enqueue.
2. Pair enqueue: in_valid=11 with addr 0/4 then 8/12, out_accept=00 -> count=4, out_valid=11, out_addr_0=0, out_addr_1=4. Then out_accept=11 for one cycle -> out_addr_0=8, out_addr_1=12, count=2.
3. Full/backpressure: enqueue pairs 0..28 (DEPTH=8) without accept -> count=8, in_ready=0 from count 7. A further in_valid=11 with addr 32/36 is ignored (count stays 8). out_accept=01 -> count=7 but in_ready stays 0; second out_accept=01 -> count=6, in_ready=1.
4. Wrap-around: stream 20 pairs (addr 0,4,...,156) while decode accepts 11 every other cycle -> out_addr_0 sequence strictly 0,8,16,... with no gap or duplicate; count never >8.
5. Compaction and partial: in_valid=10 with addr_1=0x40 -> one entry, out_valid=01, out_addr_0=0x40. Then in_valid=01 addr_0=0x44 -> out_valid=11, out_addr_1=0x44.
6. Flush priority: count=5, assert flush with in_valid=11 and out_accept=11 -> next cycle count=0, out_valid=00, in_ready=1. Next enqueue addr 0x100 appears as out_addr_0=0x100.
